// File: rtl/isp_cmd_decoder_if.sv
// isp_cmd_decoder_if
// Groups the byte-receive handshake (rx_*) and the register-write bus (wr_*)
// of the ISP command decoder. The decoder connects through the master
// modport. The host/receiver plus register-bank side uses the slave modport.
interface isp_cmd_decoder_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/isp_cmd_decoder.sv
// isp_cmd_decoder
// Parses 5-byte write frames (HEADER, ADDR, DATA_H, DATA_L, CHK) from a byte
// stream. It issues one single-cycle register write for each valid frame.
// It rejects frames with a bad checksum, an out-of-range address, or a stall
// between bytes.
// Optional build macro ISP_CMD_ACK_EN: adds a tx_valid/tx_data/tx_ready ack
// channel. The channel returns 8'h5A after a write and 8'hEE after a
// rejected frame.
module isp_cmd_decoder #(
    parameter int         REG_COUNT      = 16,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] HEADER         = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    isp_cmd_decoder_if.master    bus,
    output logic                 frame_err,
    output logic [7:0]           err_cnt
`ifdef ISP_CMD_ACK_EN
    ,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready
`endif
);

    // The counter must be able to hold TIMEOUT_CYCLES-1.
    localparam int              TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]     REG_LIMIT = 32'(REG_COUNT);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DH,
        GET_DL,
        GET_CHK,
        WRITE
    } state_t;

    state_t         state_reg;
    logic [7:0]     addr_reg;
    logic [7:0]     dh_reg;
    logic [7:0]     dl_reg;
    logic [TW-1:0]  tmo_cnt_reg;
    logic           wr_en_reg;
    logic [15:0]    wr_addr_reg;
    logic [15:0]    wr_data_reg;
    logic           frame_err_reg;
    logic [7:0]     err_cnt_reg;

    logic           accept;
    logic           in_frame;
    logic           tmo_hit;
    logic [7:0]     chk_sum;
    logic           addr_in_range;
    logic           frame_ok;
    logic           write_evt;
    logic           err_evt;
    logic           ack_pending;

    // A byte moves only when both sides agree. A stalled frame is cut off
    // in the cycle when the gap counter reaches its last value. A byte that
    // arrives in that same cycle is dropped together with the frame.
    assign accept        = bus.rx_valid && bus.rx_ready;
    assign in_frame      = (state_reg == GET_ADDR) || (state_reg == GET_DH) ||
                           (state_reg == GET_DL)   || (state_reg == GET_CHK);
    assign tmo_hit       = in_frame && (tmo_cnt_reg == TMO_LAST);

    // Checksum is an 8-bit wrapping sum of the three payload bytes. A bad
    // checksum and a bad address together still count as a single error.
    assign chk_sum       = addr_reg + dh_reg + dl_reg;
    assign addr_in_range = ({24'd0, addr_reg} < REG_LIMIT);
    assign frame_ok      = (chk_sum == bus.rx_data) && addr_in_range;

    assign write_evt     = (state_reg == GET_CHK) && !tmo_hit && accept && frame_ok;
    assign err_evt       = tmo_hit ||
                           ((state_reg == GET_CHK) && accept && !frame_ok);

    // No byte is taken during the write cycle. When acks are enabled,
    // no new frame may start until the previous ack has been taken.
    assign bus.rx_ready  = (state_reg != WRITE) &&
                           !((state_reg == IDLE) && ack_pending);

    assign bus.wr_en     = wr_en_reg;
    assign bus.wr_addr   = wr_addr_reg;
    assign bus.wr_data   = wr_data_reg;
    assign frame_err     = frame_err_reg;
    assign err_cnt       = err_cnt_reg;

    // Frame parser, gap timer and registered write/error outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            addr_reg      <= 8'd0;
            dh_reg        <= 8'd0;
            dl_reg        <= 8'd0;
            tmo_cnt_reg   <= '0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= 16'd0;
            wr_data_reg   <= 16'd0;
            frame_err_reg <= 1'b0;
            err_cnt_reg   <= 8'd0;
        end else begin
            wr_en_reg     <= 1'b0;
            frame_err_reg <= 1'b0;

            if (err_evt) begin
                frame_err_reg <= 1'b1;
                if (err_cnt_reg != 8'hFF) begin
                    err_cnt_reg <= err_cnt_reg + 8'd1;
                end
            end

            case (state_reg)
                IDLE: begin
                    tmo_cnt_reg <= '0;
                    // Bytes other than the header are discarded here
                    // and are not counted as errors.
                    if (accept && (bus.rx_data == HEADER)) begin
                        state_reg <= GET_ADDR;
                    end
                end

                GET_ADDR, GET_DH, GET_DL, GET_CHK: begin
                    if (tmo_hit) begin
                        state_reg   <= IDLE;
                        tmo_cnt_reg <= '0;
                    end else if (accept) begin
                        tmo_cnt_reg <= '0;
                        // A HEADER byte inside a frame is treated as
                        // ordinary payload. The parser does not resync.
                        case (state_reg)
                            GET_ADDR: begin
                                addr_reg  <= bus.rx_data;
                                state_reg <= GET_DH;
                            end
                            GET_DH: begin
                                dh_reg    <= bus.rx_data;
                                state_reg <= GET_DL;
                            end
                            GET_DL: begin
                                dl_reg    <= bus.rx_data;
                                state_reg <= GET_CHK;
                            end
                            default: begin
                                if (frame_ok) begin
                                    state_reg   <= WRITE;
                                    wr_en_reg   <= 1'b1;
                                    wr_addr_reg <= {8'h00, addr_reg};
                                    wr_data_reg <= {dh_reg, dl_reg};
                                end else begin
                                    state_reg   <= IDLE;
                                end
                            end
                        endcase
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    end
                end

                WRITE: begin
                    tmo_cnt_reg <= '0;
                    state_reg   <= IDLE;
                end

                default: begin
                    tmo_cnt_reg <= '0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

`ifdef ISP_CMD_ACK_EN
    localparam logic [7:0] ACK_OK  = 8'h5A;
    localparam logic [7:0] ACK_ERR = 8'hEE;

    logic       tx_valid_reg;
    logic [7:0] tx_data_reg;

    // Loads one ack byte per finished frame and holds it until the host
    // takes it. A new frame cannot finish while an ack is waiting, because
    // the idle state refuses bytes until then.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= 8'd0;
        end else if (write_evt) begin
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= ACK_OK;
        end else if (err_evt) begin
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= ACK_ERR;
        end else if (tx_valid_reg && tx_ready) begin
            tx_valid_reg <= 1'b0;
        end
    end

    assign tx_valid    = tx_valid_reg;
    assign tx_data     = tx_data_reg;
    assign ack_pending = tx_valid_reg;
`else
    assign ack_pending = 1'b0;
`endif

endmodule

// File: tb/tb_isp_cmd_decoder.sv
// tb_isp_cmd_decoder
// Directed and randomized frames for isp_cmd_decoder. Expected results come
// from frame-level rules: the checksum sum, the address range, the gap
// length, and a saturating error tally. When ISP_CMD_ACK_EN is defined,
// the bench also checks the ack channel.
module tb_isp_cmd_decoder;

    localparam int         TMO        = 16;
    localparam int         REGS       = 16;
    localparam logic [7:0] HDR        = 8'hA5;
    localparam int         WAIT_LIMIT = 40;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       frame_err;
    logic [7:0] err_cnt;
`ifdef ISP_CMD_ACK_EN
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b1;
`endif

    isp_cmd_decoder_if bus_if();

    isp_cmd_decoder #(
        .REG_COUNT      (REGS),
        .TIMEOUT_CYCLES (TMO),
        .HEADER         (HDR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
`ifdef ISP_CMD_ACK_EN
        ,
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          wr_seen  = 0;
    int          err_seen = 0;
    int          exp_wr   = 0;
    int          exp_err  = 0;
    int          exp_errcnt = 0;
    logic [15:0] exp_addr = 16'd0;
    logic [15:0] exp_data = 16'd0;

    // Pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            if (bus_if.wr_en === 1'b1) wr_seen++;
            if (frame_err === 1'b1) err_seen++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic note_err();
        exp_err++;
        if (exp_errcnt < 255) exp_errcnt++;
    endtask

    // Called at a negedge. Returns at the negedge right after the byte's
    // handshake edge.
    task automatic put_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = b;
        while (bus_if.rx_ready !== 1'b1 && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (n < WAIT_LIMIT) else begin
            bad++;
            $error("FAIL rx_ready_wait: waited=%0d limit=%0d", n, WAIT_LIMIT);
        end
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        @(negedge clk);
        check("wr_pulses",  32'(wr_seen),  32'(exp_wr));
        check("err_pulses", 32'(err_seen), 32'(exp_err));
        check("wr_addr",    32'(bus_if.wr_addr), 32'(exp_addr));
        check("wr_data",    32'(bus_if.wr_data), 32'(exp_data));
        check("err_cnt",    32'(err_cnt), 32'(exp_errcnt));
    endtask

    // Sends one frame, predicts its outcome from the checksum and range
    // rules, and checks the cycle right after the CHK handshake.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] dh,
                              input logic [7:0] dl, input logic [7:0] ck,
                              input bit do_settle);
        logic [7:0] s;
        bit         ok;
        s  = a + dh + dl;
        ok = (s == ck) && (int'(a) < REGS);
        put_byte(HDR);
        put_byte(a);
        put_byte(dh);
        put_byte(dl);
        put_byte(ck);
        check("wr_en_after_chk",     32'(bus_if.wr_en), 32'(ok));
        check("frame_err_after_chk", 32'(frame_err),    32'(!ok));
        if (ok) begin
            exp_wr++;
            exp_addr = {8'h00, a};
            exp_data = {dh, dl};
            check("rx_ready_in_write", 32'(bus_if.rx_ready), 32'(0));
        end else begin
            note_err();
        end
        check("wr_addr_now", 32'(bus_if.wr_addr), 32'(exp_addr));
        check("wr_data_now", 32'(bus_if.wr_data), 32'(exp_data));
        check("err_cnt_now", 32'(err_cnt), 32'(exp_errcnt));
`ifdef ISP_CMD_ACK_EN
        check("tx_valid_evt", 32'(tx_valid), 32'(1));
        check("tx_data_evt",  32'(tx_data),  ok ? 32'h5A : 32'hEE);
`endif
        if (do_settle) settle();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached before test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          seen_at;
        logic [7:0]  a, dh, dl, ck, s, jb;
        int          nj;

        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Values while reset is held
        check("rst_rx_ready",  32'(bus_if.rx_ready), 32'(1));
        check("rst_wr_en",     32'(bus_if.wr_en),    32'(0));
        check("rst_wr_addr",   32'(bus_if.wr_addr),  32'(0));
        check("rst_wr_data",   32'(bus_if.wr_data),  32'(0));
        check("rst_frame_err", 32'(frame_err),       32'(0));
        check("rst_err_cnt",   32'(err_cnt),         32'(0));
`ifdef ISP_CMD_ACK_EN
        check("rst_tx_valid",  32'(tx_valid), 32'(0));
        check("rst_tx_data",   32'(tx_data),  32'(0));
`endif
        reset = 1'b1;
        @(negedge clk);

        // Directed frames: valid, bad checksum, recovery, out of range
        send_frame(8'h03, 8'h12, 8'h34, 8'h49, 1);
        send_frame(8'h03, 8'h12, 8'h34, 8'h00, 1);
        send_frame(8'h01, 8'h00, 8'hFF, 8'h00, 1);
        send_frame(8'h10, 8'h00, 8'h01, 8'h11, 1);

        // Junk before a header is dropped silently
        put_byte(8'h00);
        put_byte(8'hFF);
        put_byte(8'h5A);
        send_frame(8'h07, 8'h80, 8'h01, 8'h88, 1);

        // A byte offered during the write cycle must not be taken
        send_frame(8'h05, 8'h11, 8'h22, 8'h38, 0);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = HDR;
        check("rx_ready_write_valid_high", 32'(bus_if.rx_ready), 32'(0));
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
        settle();
        send_frame(8'h01, 8'h00, 8'hFF, 8'h00, 1);

        // Stall after A5 03. The gap counter reaches TMO-1 in the TMO-th
        // cycle after the last handshake, and the pulse follows one cycle
        // later.
        put_byte(HDR);
        put_byte(8'h03);
        seen_at = 0;
        for (int k = 1; k <= TMO + 4 && seen_at == 0; k++) begin
            @(negedge clk);
            if (frame_err === 1'b1) seen_at = k;
        end
        check("timeout_latency", 32'(seen_at), 32'(TMO));
        check("timeout_rx_ready", 32'(bus_if.rx_ready), 32'(1));
        note_err();
        settle();
        send_frame(8'h03, 8'h12, 8'h34, 8'h49, 1);

        // A byte arriving in the timeout cycle is lost together with the frame
        put_byte(HDR);
        put_byte(8'h03);
        repeat (TMO - 1) @(negedge clk);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h12;
        check("tmo_cycle_rx_ready", 32'(bus_if.rx_ready), 32'(1));
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
        check("tmo_cycle_frame_err", 32'(frame_err), 32'(1));
        note_err();
        settle();
        send_frame(8'h02, 8'hBE, 8'hEF, 8'hAF, 1);

        // Reset in the middle of a frame
        put_byte(HDR);
        put_byte(8'h03);
        put_byte(8'h12);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_wr_en",     32'(bus_if.wr_en),    32'(0));
        check("mid_rst_wr_addr",   32'(bus_if.wr_addr),  32'(0));
        check("mid_rst_wr_data",   32'(bus_if.wr_data),  32'(0));
        check("mid_rst_frame_err", 32'(frame_err),       32'(0));
        check("mid_rst_err_cnt",   32'(err_cnt),         32'(0));
        check("mid_rst_rx_ready",  32'(bus_if.rx_ready), 32'(1));
        exp_addr   = 16'd0;
        exp_data   = 16'd0;
        exp_errcnt = 0;
        @(negedge clk);
        reset = 1'b1;
        put_byte(8'h34);
        put_byte(8'h49);
        settle();

        // Random frames with random junk lead-in and occasional corruption
        for (int f = 0; f < 60; f++) begin
            nj = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) begin
                jb = 8'($urandom_range(0, 255));
                if (jb == HDR) jb = 8'h00;
                put_byte(jb);
            end
            a  = 8'($urandom_range(0, 23));
            dh = 8'($urandom_range(0, 255));
            dl = 8'($urandom_range(0, 255));
            s  = a + dh + dl;
            ck = ($urandom_range(0, 3) == 0) ? (s ^ 8'($urandom_range(1, 255))) : s;
            send_frame(a, dh, dl, ck, 1);
        end

        // Enough rejected frames to saturate the error counter
        for (int f = 0; f < 300; f++) begin
            a  = 8'($urandom_range(0, 40));
            dh = 8'($urandom_range(0, 255));
            dl = 8'($urandom_range(0, 255));
            s  = a + dh + dl;
            ck = (int'(a) >= REGS) ? s : (s ^ 8'h01);
            send_frame(a, dh, dl, ck, 0);
        end
        settle();
        check("err_cnt_saturated", 32'(err_cnt), 32'(255));
        send_frame(8'h0F, 8'hCA, 8'hFE, 8'hD7, 1);

`ifdef ISP_CMD_ACK_EN
        // The ack waits 5 cycles for tx_ready and blocks new frames meanwhile
        tx_ready = 1'b0;
        send_frame(8'h02, 8'hAB, 8'hCD, 8'h7A, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("ack_hold_valid",    32'(tx_valid), 32'(1));
            check("ack_hold_data",     32'(tx_data),  32'h5A);
            check("ack_hold_rx_ready", 32'(bus_if.rx_ready), 32'(0));
        end
        tx_ready = 1'b1;
        @(negedge clk);
        check("ack_taken_valid",    32'(tx_valid), 32'(0));
        check("ack_taken_rx_ready", 32'(bus_if.rx_ready), 32'(1));
        settle();
        send_frame(8'h02, 8'hAB, 8'hCD, 8'h00, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
